// File: rtl/fpnew_pipe_out.sv
// fpnew_pipe_out: output-side retiming pipeline between an FPU operation unit core and
// the result arbiter. Carries result, status flags, extension bit, tag and aux through
// NumPipeRegs register stages with a valid/ready handshake, bubble collapsing, a
// synchronous flush and a busy indication. NumPipeRegs = 0 is a combinational passthrough.
//
// status_i/status_o use the fpnew status_t bit layout {NV, DZ, OF, UF, NX}, MSB first.
//
// Build option: define FPNEW_PIPE_OUT_SKID_EN to add a one-entry skid register after the
// last stage. This removes the combinational path from out_ready_i to in_ready_o without
// adding latency.
module fpnew_pipe_out #(
   parameter int unsigned Width       = 32,
   parameter int unsigned NumPipeRegs = 0,
   parameter type         TagType     = logic,
   parameter type         AuxType     = logic
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] result_i,
   input  logic [4:0]       status_i,
   input  logic             extension_bit_i,
   input  TagType           tag_i,
   input  AuxType           aux_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             flush_i,
   output logic [Width-1:0] result_o,
   output logic [4:0]       status_o,
   output logic             extension_bit_o,
   output TagType           tag_o,
   output AuxType           aux_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             busy_o
);

   // View of the item leaving the last register stage (or the inputs when there are none)
   logic [Width-1:0] last_result;
   logic [4:0]       last_status;
   logic             last_ext;
   TagType           last_tag;
   AuxType           last_aux;
   logic             last_valid;
   logic             last_ready;
   logic             pipe_busy;

   if (NumPipeRegs == 0) begin : gen_passthrough
      // Without registers the clock, reset and flush have nothing to act on.
      logic unused_passthrough;
      assign unused_passthrough = ^{clk_i, rst_ni, flush_i};

      assign last_result = result_i;
      assign last_status = status_i;
      assign last_ext    = extension_bit_i;
      assign last_tag    = tag_i;
      assign last_aux    = aux_i;
      assign last_valid  = in_valid_i;
      assign pipe_busy   = 1'b0;
      assign in_ready_o  = last_ready;
   end else begin : gen_pipe
      logic [Width-1:0]       result_q [NumPipeRegs];
      logic [4:0]             status_q [NumPipeRegs];
      logic                   ext_q    [NumPipeRegs];
      TagType                 tag_q    [NumPipeRegs];
      AuxType                 aux_q    [NumPipeRegs];
      logic [NumPipeRegs-1:0] valid_q;

      logic [Width-1:0]       result_d [NumPipeRegs];
      logic [4:0]             status_d [NumPipeRegs];
      logic                   ext_d    [NumPipeRegs];
      TagType                 tag_d    [NumPipeRegs];
      AuxType                 aux_d    [NumPipeRegs];
      logic [NumPipeRegs-1:0] valid_d;
      logic [NumPipeRegs-1:0] stage_ready;

      // A stage is blocked only if it and every stage after it are full and the exit is stalled.
      always_comb begin
         logic blocked;
         stage_ready = '0;
         blocked     = ~last_ready;
         for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
            blocked        = blocked & valid_q[i];
            stage_ready[i] = ~blocked;
         end
      end

      // Each stage is fed by the previous one; stage 0 by the unit core.
      always_comb begin
         for (int i = 0; i < int'(NumPipeRegs); i++) begin
            result_d[i] = '0;
            status_d[i] = '0;
            ext_d[i]    = 1'b0;
            tag_d[i]    = '0;
            aux_d[i]    = '0;
         end
         valid_d     = '0;
         result_d[0] = result_i;
         status_d[0] = status_i;
         ext_d[0]    = extension_bit_i;
         tag_d[0]    = tag_i;
         aux_d[0]    = aux_i;
         valid_d[0]  = in_valid_i;
         for (int i = 1; i < int'(NumPipeRegs); i++) begin
            result_d[i] = result_q[i-1];
            status_d[i] = status_q[i-1];
            ext_d[i]    = ext_q[i-1];
            tag_d[i]    = tag_q[i-1];
            aux_d[i]    = aux_q[i-1];
            valid_d[i]  = valid_q[i-1];
         end
      end

      // Valid bits advance on stage ready; flush wins over any concurrent accept.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= '0;
         end else if (flush_i) begin
            valid_q <= '0;
         end else begin
            valid_q <= (valid_q & ~stage_ready) | (valid_d & stage_ready);
         end
      end

      // Payload only moves when a real item is taken, so idle cycles leave the data alone.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
               result_q[i] <= '0;
               status_q[i] <= '0;
               ext_q[i]    <= 1'b0;
               tag_q[i]    <= '0;
               aux_q[i]    <= '0;
            end
         end else begin
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
               if (stage_ready[i] && valid_d[i]) begin
                  result_q[i] <= result_d[i];
                  status_q[i] <= status_d[i];
                  ext_q[i]    <= ext_d[i];
                  tag_q[i]    <= tag_d[i];
                  aux_q[i]    <= aux_d[i];
               end
            end
         end
      end

      assign last_result = result_q[NumPipeRegs-1];
      assign last_status = status_q[NumPipeRegs-1];
      assign last_ext    = ext_q[NumPipeRegs-1];
      assign last_tag    = tag_q[NumPipeRegs-1];
      assign last_aux    = aux_q[NumPipeRegs-1];
      assign last_valid  = valid_q[NumPipeRegs-1];
      assign pipe_busy   = |valid_q;
      assign in_ready_o  = stage_ready[0];
   end

`ifdef FPNEW_PIPE_OUT_SKID_EN
   logic [Width-1:0] skid_result_q;
   logic [4:0]       skid_status_q;
   logic             skid_ext_q;
   TagType           skid_tag_q;
   AuxType           skid_aux_q;
   logic             skid_full_q;
   logic             skid_capture;

   // Upstream sees only the skid occupancy, never out_ready_i directly.
   assign last_ready   = ~skid_full_q;
   assign skid_capture = ~skid_full_q & last_valid & ~out_ready_i;

   // Skid fills when the exiting item is refused and empties once downstream takes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_full_q <= 1'b0;
      end else if (flush_i) begin
         skid_full_q <= 1'b0;
      end else if (skid_capture) begin
         skid_full_q <= 1'b1;
      end else if (out_ready_i) begin
         skid_full_q <= 1'b0;
      end
   end

   // Skid payload captured only together with a refused item.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_result_q <= '0;
         skid_status_q <= '0;
         skid_ext_q    <= 1'b0;
         skid_tag_q    <= '0;
         skid_aux_q    <= '0;
      end else if (skid_capture) begin
         skid_result_q <= last_result;
         skid_status_q <= last_status;
         skid_ext_q    <= last_ext;
         skid_tag_q    <= last_tag;
         skid_aux_q    <= last_aux;
      end
   end

   assign result_o        = skid_full_q ? skid_result_q : last_result;
   assign status_o        = skid_full_q ? skid_status_q : last_status;
   assign extension_bit_o = skid_full_q ? skid_ext_q    : last_ext;
   assign tag_o           = skid_full_q ? skid_tag_q    : last_tag;
   assign aux_o           = skid_full_q ? skid_aux_q    : last_aux;
   assign out_valid_o     = skid_full_q | last_valid;
   assign busy_o          = in_valid_i | pipe_busy | skid_full_q;
`else
   assign last_ready      = out_ready_i;
   assign result_o        = last_result;
   assign status_o        = last_status;
   assign extension_bit_o = last_ext;
   assign tag_o           = last_tag;
   assign aux_o           = last_aux;
   assign out_valid_o     = last_valid;
   assign busy_o          = in_valid_i | pipe_busy;
`endif

endmodule

// File: tb/tb_fpnew_pipe_out.sv
// Directed bench for fpnew_pipe_out: four instances (0, 1, 2 and 3 register stages)
// share the payload and flush inputs; each has its own valid/ready handshake.
module tb_fpnew_pipe_out;

   typedef logic [7:0] tag_t;
   typedef logic [3:0] aux_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] res_in;
   logic [4:0]  st_in;
   logic        ext_in;
   tag_t        tag_in;
   aux_t        aux_in;
   logic        flush;

   logic v0, v1, v2, v3;
   logic r0, r1, r2, r3;
   logic irdy0, irdy1, irdy2, irdy3;
   logic ov0, ov1, ov2, ov3;
   logic busy0, busy1, busy2, busy3;
   logic [31:0] res0, res1, res2, res3;
   logic [4:0]  st0, st1, st2, st3;
   logic        ext0, ext1, ext2, ext3;
   tag_t        tag0, tag1, tag2, tag3;
   aux_t        aux0, aux1, aux2, aux3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpnew_pipe_out #(.Width(32), .NumPipeRegs(0), .TagType(tag_t), .AuxType(aux_t)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .result_i(res_in), .status_i(st_in), .extension_bit_i(ext_in),
      .tag_i(tag_in), .aux_i(aux_in), .in_valid_i(v0), .in_ready_o(irdy0), .flush_i(flush),
      .result_o(res0), .status_o(st0), .extension_bit_o(ext0), .tag_o(tag0), .aux_o(aux0),
      .out_valid_o(ov0), .out_ready_i(r0), .busy_o(busy0));

   fpnew_pipe_out #(.Width(32), .NumPipeRegs(1), .TagType(tag_t), .AuxType(aux_t)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .result_i(res_in), .status_i(st_in), .extension_bit_i(ext_in),
      .tag_i(tag_in), .aux_i(aux_in), .in_valid_i(v1), .in_ready_o(irdy1), .flush_i(flush),
      .result_o(res1), .status_o(st1), .extension_bit_o(ext1), .tag_o(tag1), .aux_o(aux1),
      .out_valid_o(ov1), .out_ready_i(r1), .busy_o(busy1));

   fpnew_pipe_out #(.Width(32), .NumPipeRegs(2), .TagType(tag_t), .AuxType(aux_t)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .result_i(res_in), .status_i(st_in), .extension_bit_i(ext_in),
      .tag_i(tag_in), .aux_i(aux_in), .in_valid_i(v2), .in_ready_o(irdy2), .flush_i(flush),
      .result_o(res2), .status_o(st2), .extension_bit_o(ext2), .tag_o(tag2), .aux_o(aux2),
      .out_valid_o(ov2), .out_ready_i(r2), .busy_o(busy2));

   fpnew_pipe_out #(.Width(32), .NumPipeRegs(3), .TagType(tag_t), .AuxType(aux_t)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .result_i(res_in), .status_i(st_in), .extension_bit_i(ext_in),
      .tag_i(tag_in), .aux_i(aux_in), .in_valid_i(v3), .in_ready_o(irdy3), .flush_i(flush),
      .result_o(res3), .status_o(st3), .extension_bit_o(ext3), .tag_o(tag3), .aux_o(aux3),
      .out_valid_o(ov3), .out_ready_i(r3), .busy_o(busy3));

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Step to 1 time unit after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      res_in = '0; st_in = '0; ext_in = 1'b0; tag_in = '0; aux_in = '0;
      v0 = 0; v1 = 0; v2 = 0; v3 = 0;
      r0 = 1; r1 = 1; r2 = 1; r3 = 1;
      #1;
      // reset state
      chk("rst_ov2", ov2, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_res2", res2, 0);
      chk("rst_st2", st2, 0);
      chk("rst_tag2", tag2, 0);
      chk("rst_ov3", ov3, 0);
      chk("rst_busy3", busy3, 0);
      chk("rst_ov1", ov1, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      // back-to-back tags 1..5, two-cycle latency
      r2 = 1;
      for (int c = 0; c < 8; c++) begin
         cyc();
         v2 = (c < 5);
         tag_in = 8'(c + 1);
         #1;
         chk("t1_ovalid", ov2, (c >= 2 && c <= 6));
         if (c >= 2 && c <= 6) chk("t1_tag", tag2, c - 1);
      end

`ifndef FPNEW_PIPE_OUT_SKID_EN
      // two items fill a stalled 2-stage pipe, third is refused
      r2 = 0;
      cyc(); v2 = 1; tag_in = 8'd7; #1; chk("t2_rdy_a", irdy2, 1);
      cyc(); tag_in = 8'd8; #1; chk("t2_rdy_b", irdy2, 1);
      cyc(); tag_in = 8'd9; #1;
      chk("t2_rdy_full", irdy2, 0);
      chk("t2_ov", ov2, 1);
      chk("t2_head", tag2, 7);
      cyc(); v2 = 0; r2 = 1; #1; chk("t2_out7_v", ov2, 1); chk("t2_out7", tag2, 7);
      cyc(); #1; chk("t2_out8_v", ov2, 1); chk("t2_out8", tag2, 8);
      cyc(); #1; chk("t2_empty", ov2, 0); chk("t2_busy", busy2, 0);

      // bubbles collapse in a stalled 3-stage pipe
      r3 = 0;
      cyc(); v3 = 1; tag_in = 8'h11; #1; chk("t3_rdy0", irdy3, 1);
      cyc(); v3 = 0;
      cyc();
      cyc(); v3 = 1; tag_in = 8'h12; #1;
      chk("t3_head_v", ov3, 1); chk("t3_head", tag3, 8'h11); chk("t3_rdy3", irdy3, 1);
      cyc(); tag_in = 8'h13; #1; chk("t3_rdy4", irdy3, 1);
      cyc(); tag_in = 8'h14; #1; chk("t3_rdy5", irdy3, 0);
      cyc(); v3 = 0; r3 = 1; #1; chk("t3_o1", tag3, 8'h11);
      cyc(); #1; chk("t3_o2_v", ov3, 1); chk("t3_o2", tag3, 8'h12);
      cyc(); #1; chk("t3_o3_v", ov3, 1); chk("t3_o3", tag3, 8'h13);
      cyc(); #1; chk("t3_empty", ov3, 0);

      // passthrough follows inputs combinationally
      cyc(); v0 = 1; r0 = 0; res_in = 32'hCAFE_F00D; tag_in = 8'h3C; #1;
      chk("p_ov", ov0, 1); chk("p_res", res0, 32'hCAFE_F00D); chk("p_tag", tag0, 8'h3C);
      chk("p_rdy_lo", irdy0, 0); chk("p_busy", busy0, 1);
      r0 = 1; #1; chk("p_rdy_hi", irdy0, 1);
      v0 = 0; #1; chk("p_ov_lo", ov0, 0); chk("p_busy_lo", busy0, 0);

      // single stage, one-cycle latency
      r1 = 1;
      cyc(); v1 = 1; tag_in = 8'h41; #1; chk("s1_ov0", ov1, 0);
      cyc(); v1 = 0; #1; chk("s1_ov1", ov1, 1); chk("s1_tag", tag1, 8'h41);
      cyc(); #1; chk("s1_ov2", ov1, 0);
`else
      // skid captures a refused item; in_ready_o ignores out_ready_i
      r1 = 1;
      cyc(); v1 = 1; tag_in = 8'hA1; #1; chk("sk_rdy0", irdy1, 1);
      cyc(); tag_in = 8'hA2; r1 = 0; #1;
      chk("sk_outA_v", ov1, 1); chk("sk_outA", tag1, 8'hA1); chk("sk_rdy1", irdy1, 1);
      cyc(); tag_in = 8'hA3; r1 = 1; #1;
      chk("sk_full_rdy", irdy1, 0); chk("sk_skidA", tag1, 8'hA1); chk("sk_busy", busy1, 1);
      r1 = 0; #1; chk("sk_rdy_nopath0", irdy1, 0);
      r1 = 1; #1;
      cyc(); #1; chk("sk_outB", tag1, 8'hA2); chk("sk_rdy3", irdy1, 1);
      r1 = 0; #1; chk("sk_rdy_nopath1", irdy1, 1);
      r1 = 1; #1;
      cyc(); v1 = 0; #1; chk("sk_outC_v", ov1, 1); chk("sk_outC", tag1, 8'hA3);
      cyc(); #1; chk("sk_empty", ov1, 0); chk("sk_busy_lo", busy1, 0);
`endif

      // flush two items in flight while a new item is offered
      r3 = 0;
      cyc(); v3 = 1; tag_in = 8'h21;
      cyc(); tag_in = 8'h22;
      cyc(); tag_in = 8'h23; flush = 1; #1;
      chk("fl_rdy", irdy3, 1); chk("fl_busy_pre", busy3, 1); chk("fl_ov_pre", ov3, 0);
      cyc(); flush = 0; v3 = 0; #1;
      chk("fl_busy", busy3, 0); chk("fl_ov", ov3, 0);
      r3 = 1;
      for (int c = 0; c < 4; c++) begin
         cyc(); #1; chk("fl_nothing", ov3, 0);
      end

      // payload integrity and hold under stall
      r2 = 0;
      cyc(); v2 = 1; res_in = 32'h7FC0_0000; st_in = 5'b10001; ext_in = 1; tag_in = 8'h5A; aux_in = 4'hA; #1;
      chk("d_rdy", irdy2, 1);
      cyc(); v2 = 0; res_in = 32'hDEAD_BEEF; st_in = 5'b00100; ext_in = 0; tag_in = 8'h00; aux_in = 4'h0;
      cyc(); v2 = 1; res_in = 32'h1234_5678; st_in = 5'b01110; ext_in = 0; tag_in = 8'hA5; aux_in = 4'h5; #1;
      chk("d_ov", ov2, 1); chk("d_res", res2, 32'h7FC0_0000); chk("d_st", st2, 5'b10001);
      chk("d_ext", ext2, 1); chk("d_tag", tag2, 8'h5A); chk("d_aux", aux2, 4'hA);
      cyc(); v2 = 0; #1;
      chk("d_hold_res", res2, 32'h7FC0_0000); chk("d_hold_st", st2, 5'b10001); chk("d_hold_ext", ext2, 1);
      cyc(); r2 = 1; #1; chk("d_rel_v", ov2, 1); chk("d_rel_res", res2, 32'h7FC0_0000);
      cyc(); #1; chk("d_2nd_v", ov2, 1); chk("d_2nd_res", res2, 32'h1234_5678); chk("d_2nd_st", st2, 5'b01110);
      cyc(); #1; chk("d_empty", ov2, 0);

      // reset mid-operation drops the in-flight item
      r2 = 0;
      cyc(); v2 = 1; tag_in = 8'h31;
      cyc(); v2 = 0;
      cyc(); #1; chk("rm_ov_pre", ov2, 1);
      rst_n = 0; #1;
      chk("rm_ov", ov2, 0); chk("rm_busy", busy2, 0); chk("rm_rdy", irdy2, 1);
      cyc(); rst_n = 1; r2 = 1;
      for (int c = 0; c < 3; c++) begin
         cyc(); #1; chk("rm_nothing", ov2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
